mux_scan_sequencer: RTL and testbench

- Upstream/downstream companion to the 8:1 mux. Drives the mux `sel` through channels 0..7 and samples the 1-bit mux output after a programmable settle time.
- Packs the eight samples into one byte and hands the byte off with a valid/ready handshake.
- Turns the mux into a parallel-capture path for the consuming logic.

---
 rtl/mux_scan_sequencer_pkg.sv | 10 +
 rtl/mux_scan_sequencer.sv | 105 ++++++++++
 tb/tb_mux_scan_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_sequencer_pkg: shared state encoding and channel geometry for the mux scan sequencer.
package mux_scan_sequencer_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W = 3;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps an 8:1 mux select, samples its output after a settle time,
// and hands the packed byte off over valid/ready.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mux_out,
    output logic [SEL_W-1:0] sel,
    output logic [7:0]       data,
    output logic             data_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    state_t state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [7:0] data_q, data_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    sel_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SCAN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    shadow_d[sel_q] = mux_out;
                    cnt_d = '0;
                    // On the last channel the freshly written shadow already is the full byte.
                    if (sel_q != SEL_LAST) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else begin
                        state_d = S_DONE;
                        data_d  = shadow_d;
                        valid_d = 1'b1;
                        sel_d   = '0;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d = S_SCAN;
                        sel_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sel        = sel_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: two sequencers (settle 1 and 3) closed around behavioural muxes,
// checked every cycle against an elapsed-time scan model.
module tb_mux_scan_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] start = '0, out_ready = '0, noise = '0;
    logic [1:0] mux_out, dv, busy;
    logic [2:0] sel [2];
    logic [7:0] data [2];
    logic [7:0] in_v [2];
    bit cmp_en = 1'b0, noise_on = 1'b0;
    int checks = 0, errors = 0;

    assign mux_out[0] = in_v[0][sel[0]] ^ noise[0];
    assign mux_out[1] = in_v[1][sel[1]] ^ noise[1];

    mux_scan_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .mux_out(mux_out[0]), .sel(sel[0]),
        .data(data[0]), .data_valid(dv[0]), .out_ready(out_ready[0]), .busy(busy[0]));
    mux_scan_sequencer #(.SETTLE_CYCLES(3), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .mux_out(mux_out[1]), .sel(sel[1]),
        .data(data[1]), .data_valid(dv[1]), .out_ready(out_ready[1]), .busy(busy[1]));

    function automatic int settle(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: ph 0=idle 1=scanning 2=holding; age = edges elapsed since the start edge.
    int ph [2];
    int age [2];
    logic [7:0] cap [2];
    logic [7:0] m_data [2];
    bit m_valid [2];
    bit m_busy [2];

    always @(posedge clk) begin
        logic [1:0] st, rd, mo;
        st = start;
        rd = out_ready;
        mo = mux_out;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0; age[i] = 0; m_data[i] = '0; m_valid[i] = 0; m_busy[i] = 0;
            end else if (ph[i] == 0) begin
                if (st[i]) begin ph[i] = 1; age[i] = 0; m_busy[i] = 1; end
            end else if (ph[i] == 1) begin
                age[i]++;
                if (age[i] % settle(i) == 0) begin
                    cap[i][age[i] / settle(i) - 1] = mo[i];
                    if (age[i] == 8 * settle(i)) begin
                        ph[i] = 2; m_valid[i] = 1; m_data[i] = cap[i];
                    end
                end
            end else if (rd[i]) begin
                m_valid[i] = 0;
                if (st[i]) begin ph[i] = 1; age[i] = 0; end
                else begin ph[i] = 0; m_busy[i] = 0; end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            noise[i] = (noise_on && ph[i] == 1 && (age[i] + 1) % settle(i) != 0) ? 1'($urandom) : 1'b0;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("sel%0d", i), sel[i], (ph[i] == 1) ? age[i] / settle(i) : 0);
                chk($sformatf("data%0d", i), data[i], m_data[i]);
                chk($sformatf("valid%0d", i), dv[i], m_valid[i]);
                chk($sformatf("busy%0d", i), busy[i], m_busy[i]);
            end
        end
    end

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk) start = m;
        @(negedge clk) start = '0;
    endtask

    task automatic wait_valid(input int i, input string nm);
        int n = 0;
        while (!dv[i] && n < 100) begin @(negedge clk); n++; end
        chk(nm, dv[i], 1);
    endtask

    initial begin
        int n, l0, l1;
        in_v[0] = 8'hAA;
        in_v[1] = 8'hAA;
        @(negedge clk) cmp_en = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_data", data[0], 8'h00);
        chk("idle_busy", busy, 2'b00);
        chk("idle_valid", dv, 2'b00);

        noise_on = 1'b1;
        @(negedge clk) start = 2'b11;
        @(negedge clk) start = 2'b00;
        n = 0; l0 = -1; l1 = -1;
        while ((l0 < 0 || l1 < 0) && n < 100) begin
            @(negedge clk); n++;
            if (dv[0] && l0 < 0) l0 = n;
            if (dv[1] && l1 < 0) l1 = n;
        end
        chk("latency_s1", l0, 8);
        chk("latency_s3", l1, 24);
        chk("scan_s1", data[0], 8'hAA);
        chk("model_s1", m_data[0], 8'hAA);
        chk("scan_s3", data[1], 8'hAA);

        repeat (20) @(negedge clk) start = 2'($urandom);
        start = '0;
        chk("hold_data", data[0], 8'hAA);
        chk("hold_valid", dv, 2'b11);
        chk("hold_busy", busy, 2'b11);

        @(negedge clk) begin in_v[0] = 8'h33; start = 2'b01; out_ready = 2'b01; end
        @(negedge clk) begin start = '0; out_ready = '0; end
        chk("b2b_busy", busy[0], 1);
        chk("b2b_valid", dv[0], 0);
        wait_valid(0, "b2b_done");
        chk("b2b_data", data[0], 8'h33);

        @(negedge clk) out_ready = 2'b11;
        @(negedge clk) out_ready = 2'b00;
        chk("release_busy", busy, 2'b00);
        chk("release_valid", dv, 2'b00);

        pulse_start(2'b11);
        n = 0;
        while (sel[0] != 3'd4 && n < 50) begin @(negedge clk); n++; end
        chk("reach_sel4", sel[0], 3'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sel", sel[0], 3'd0);
        chk("midrst_busy", busy, 2'b00);
        chk("midrst_data", data[1], 8'h00);
        rst = 1'b0;

        in_v[0] = 8'($urandom);
        in_v[1] = 8'($urandom);
        pulse_start(2'b11);
        wait_valid(1, "fresh_done");
        chk("fresh_s1", data[0], in_v[0]);
        chk("fresh_s3", data[1], in_v[1]);
        @(negedge clk) out_ready = 2'b11;

        repeat (800) begin
            @(negedge clk);
            start = 2'($urandom);
            out_ready = 2'($urandom);
            if ($urandom % 8 == 0) in_v[0] = 8'($urandom);
            if ($urandom % 8 == 0) in_v[1] = 8'($urandom);
            rst = ($urandom % 200 == 0);
        end
        @(negedge clk) begin rst = 1'b0; start = '0; end
        @(negedge clk) cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
